mm_mac_engine: RTL
==================

MM_MAC_ENGINE -- requirements
Module: mm_mac_engine

Interface
REQ-001 SHALL have parameter IN_DIM, default 784: input vector length, range 1..1024.
REQ-002 SHALL have parameter OUT_DIM, default 5: output neuron count; IN_DIM*OUT_DIM at most 65536.
REQ-003 SHALL have parameter FRAC_BITS, default 16: fixed-point fraction bits removed after accumulation.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to run a full matrix-vector product.
REQ-007 SHALL have port busy, output, 1: high while a product is running.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the last output is written.
REQ-009 SHALL have port weight_addr, output, 16: flat index into the weight memory.
REQ-010 SHALL have port weight_data, input, signed 32: weight word; combinational, valid in the same cycle as weight_addr.
REQ-011 SHALL have port in_addr, output, 16: activation index, 0..IN_DIM-1.
REQ-012 SHALL have port in_data, input, signed 32: activation word; combinational, valid in the same cycle as in_addr.
REQ-013 SHALL have port out_wr_en, output, 1: one-cycle write strobe for a result.
REQ-014 SHALL have port out_addr, output, 16: result index, 0..OUT_DIM-1.
REQ-015 SHALL have port out_data, output, signed 32: result value.

Function
REQ-016 SHALL implement a state machine with states IDLE, MAC, WRITE and DONE.
REQ-017 SHALL move from IDLE to MAC on start=1, clearing the row, column and address counters and the accumulator.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL, in MAC, drive weight_addr = row*IN_DIM + col from an incrementing counter (no multiplier), drive in_addr = col, and add weight_data*in_data (full 64-bit signed product) to a 74-bit signed accumulator each cycle.
REQ-020 SHALL leave MAC for WRITE after the col = IN_DIM-1 term has been accumulated.
REQ-021 SHALL, in WRITE, assert out_wr_en for exactly one cycle with out_addr = row and out_data = sat32(acc >>> FRAC_BITS), using an arithmetic shift.
REQ-022 SHALL implement sat32 by clipping to 0x7FFFFFFF when above that value and to 0x80000000 when below it.
REQ-023 SHALL, leaving WRITE, clear the accumulator and col and increment row; it SHALL go to MAC if row < OUT_DIM-1, otherwise to DONE.
REQ-024 SHALL, in DONE, assert done for one cycle and then return to IDLE.
REQ-025 SHALL hold busy=1 in MAC, WRITE and DONE, and busy=0 in IDLE.
REQ-026 SHALL take OUT_DIM*(IN_DIM+1)+1 cycles from the first MAC cycle to the done cycle inclusive.
REQ-027 SHALL hold weight_addr and in_addr at their last MAC values during WRITE and DONE, and at 0 in IDLE.
REQ-028 SHALL handle IN_DIM=1 as one MAC cycle per row followed by WRITE.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, go to IDLE and clear the accumulator, the counters, busy, done, out_wr_en, weight_addr, in_addr, out_addr and out_data to 0, from any state.
REQ-030 SHALL, on reset in mid-operation, abandon the partial row with no further out_wr_en or done.
REQ-031 SHALL give reset priority over a start asserted in the same cycle.

Configuration
REQ-032 SHALL, when MM_RELU_EN is defined, replace negative sat32 results with 0 before out_data; when MM_RELU_EN is undefined, out_data SHALL be the signed saturated value unchanged.

Verification (IN_DIM=4, OUT_DIM=2, FRAC_BITS=0 unless noted)
REQ-033 Bench SHALL cover: weights 1..8, activations all 1, start -> out_wr_en with (0,10) and then (1,26); done exactly 11 cycles after the first MAC cycle.
REQ-034 Bench SHALL cover: weight_addr sequence -> 0,1,2,3, held for the WRITE cycle, then 4,5,6,7; in_addr -> 0..3 repeated.
REQ-035 Bench SHALL cover: all weights -1, activations 5 -> out_data -20 for both rows without MM_RELU_EN, and 0 with MM_RELU_EN.
REQ-036 Bench SHALL cover: weights 0x7FFFFFFF, activations 0x7FFFFFFF -> out_data 0x7FFFFFFF; weights 0x80000000, activations 0x7FFFFFFF -> out_data 0x80000000.
REQ-037 Bench SHALL cover: FRAC_BITS=16, weights 0x00010000, activations 0x00008000 (0.5) -> out_data 0x00020000.
REQ-038 Bench SHALL cover: start re-pulsed while busy -> no restart and identical results; reset on the 3rd MAC cycle -> busy=0 on the next cycle with no writes; a fresh start then reproduces REQ-033.

Source files
------------

// File: rtl/mm_mac_engine.sv
// Sequential matrix-vector multiply-accumulate engine: one MAC term per cycle, one result write per row.
// Optional build macro MM_RELU_EN clamps negative saturated results to zero before they are written.
module mm_mac_engine #(
    parameter int IN_DIM    = 784,
    parameter int OUT_DIM   = 5,
    parameter int FRAC_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [15:0]        weight_addr,
    input  logic signed [31:0] weight_data,
    output logic [15:0]        in_addr,
    input  logic signed [31:0] in_data,
    output logic               out_wr_en,
    output logic [15:0]        out_addr,
    output logic signed [31:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0]        LAST_COL = 16'(IN_DIM - 1);
    localparam logic [15:0]        LAST_ROW = 16'(OUT_DIM - 1);
    localparam logic signed [73:0] SAT_MAX  = 74'sd2147483647;
    localparam logic signed [73:0] SAT_MIN  = -74'sd2147483648;

    state_t             state_q, state_d;
    logic [15:0]        row_q, row_d;
    logic [15:0]        col_q, col_d;
    logic [15:0]        waddr_q, waddr_d;
    logic signed [73:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_wr_en_q, out_wr_en_d;
    logic [15:0]        out_addr_q, out_addr_d;
    logic signed [31:0] out_data_q, out_data_d;

    logic signed [63:0] prod;
    logic signed [73:0] acc_sum;
    logic signed [73:0] shifted;
    logic signed [31:0] sat_val;
    logic signed [31:0] result;

    // Full-width signed product, then sign-extended into the wide accumulator.
    assign prod    = $signed({{32{weight_data[31]}}, weight_data})
                   * $signed({{32{in_data[31]}}, in_data});
    assign acc_sum = acc_q + $signed({{10{prod[63]}}, prod});
    assign shifted = acc_sum >>> FRAC_BITS;

    always_comb begin
        sat_val = shifted[31:0];
        if (shifted > SAT_MAX) begin
            sat_val = 32'sh7FFF_FFFF;
        end else if (shifted < SAT_MIN) begin
            sat_val = 32'sh8000_0000;
        end
    end

`ifdef MM_RELU_EN
    assign result = sat_val[31] ? 32'sd0 : sat_val;
`else
    assign result = sat_val;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        waddr_d    = waddr_q;
        acc_d      = acc_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    row_d   = 16'd0;
                    col_d   = 16'd0;
                    waddr_d = 16'd0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                if (col_q == LAST_COL) begin
                    // Result of the final term is captured so it appears during WRITE.
                    state_d    = WRITE;
                    out_addr_d = row_q;
                    out_data_d = result;
                end else begin
                    col_d   = col_q + 16'd1;
                    waddr_d = waddr_q + 16'd1;
                end
            end
            WRITE: begin
                acc_d = '0;
                row_d = row_q + 16'd1;
                if (row_q == LAST_ROW) begin
                    // Addresses stay at their last MAC values through DONE.
                    state_d = DONE;
                end else begin
                    state_d = MAC;
                    col_d   = 16'd0;
                    waddr_d = waddr_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = 16'd0;
                col_d   = 16'd0;
                waddr_d = 16'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        out_wr_en_d = (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= 16'd0;
            col_q       <= 16'd0;
            waddr_q     <= 16'd0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_wr_en_q <= 1'b0;
            out_addr_q  <= 16'd0;
            out_data_q  <= 32'sd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            waddr_q     <= waddr_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_wr_en_q <= out_wr_en_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign weight_addr = waddr_q;
    assign in_addr     = col_q;
    assign out_wr_en   = out_wr_en_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;

endmodule
